// File: rtl/bingo_pkg.sv
// Shared types and helpers for the BinGo game: FSM states, keypad codes
// and the hex-digit to 7-segment decoder.
package bingo_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_START = 3'd0,
    ST_IDLE       = 3'd1,
    ST_COMPARE    = 3'd2,
    ST_HOLD       = 3'd3,
    ST_END        = 3'd4
  } state_t;

  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;

  // Segments packed {g,f,e,d,c,b,a}, lit when 1.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bingo_top_keypad_scanner.sv
// 4x3 keypad scanner: rotates the row drive until a column answers, then
// debounces press and release and emits one key code with a single-cycle strobe.
module keypad_scanner
  import bingo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_COUNT = 500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] i_cols,
  output logic [3:0] o_rows,
  output logic [3:0] o_key,
  output logic       o_key_valid
);

  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_COUNT - 1);

  logic [3:0]  r_rows;
  logic [2:0]  r_colsPrev;
  logic [31:0] r_cnt;
  logic        r_held;
  logic [3:0]  r_key;
  logic        r_valid;

  logic w_single;
  logic w_stable;

  function automatic logic [3:0] decodeKey(input logic [3:0] row, input logic [2:0] col);
    logic [3:0] c;
    logic [3:0] k;
    c = col[2] ? 4'd0 : (col[1] ? 4'd1 : 4'd2);
    case (row)
      4'b1000: k = 4'd1 + c;
      4'b0100: k = 4'd4 + c;
      4'b0010: k = 4'd7 + c;
      default: k = (c == 4'd0) ? KEY_A : ((c == 4'd1) ? 4'd0 : KEY_B);
    endcase
    return k;
  endfunction

  assign w_single = (i_cols == 3'b100) || (i_cols == 3'b010) || (i_cols == 3'b001);
  // While a key is held we are counting quiet cycles, otherwise identical active ones.
  assign w_stable = r_held ? (i_cols == 3'b000)
                           : ((i_cols != 3'b000) && (i_cols == r_colsPrev));

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_rows     <= 4'b1000;
      r_colsPrev <= 3'b000;
      r_cnt      <= '0;
      r_held     <= 1'b0;
      r_key      <= 4'h0;
      r_valid    <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_colsPrev <= i_cols;
      if (i_cols == 3'b000) begin
        r_rows <= {r_rows[0], r_rows[3:1]};
      end
      if (!w_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt  <= '0;
        r_held <= !r_held;
        if (!r_held && w_single) begin
          r_valid <= 1'b1;
          r_key   <= decodeKey(r_rows, i_cols);
        end
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign o_rows      = r_rows;
  assign o_key       = r_key;
  assign o_key_valid = r_valid;

endmodule

// File: rtl/bingo_top.sv
// BinGo game top: card entry from the keypad, LFSR/hack draws, card matching
// and score display. Optional macro BINGO_HACK_EN enables the hack_number guess.
module bingo_top
  import bingo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_COUNT = 500000,
  parameter int unsigned HOLD_COUNT     = 50000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  keyboard_cols,
  input  logic [7:0]  hack_number,
  input  logic        load_hack,
  input  logic        next,
  output logic [3:0]  keyboard_rows,
  output logic [6:0]  hex_selcted_number_1,
  output logic [6:0]  hex_selcted_number_2,
  output logic [6:0]  hex_gessed_number_1,
  output logic [6:0]  hex_gessed_number_2,
  output logic [15:0] game_state_leds
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_COUNT - 1);

  state_t      r_state;
  logic [7:0]  r_mem [16];
  logic [7:0]  r_entry;
  logic        r_half;
  logic [4:0]  r_wrPtr;
  logic [7:0]  r_guess;
  logic [15:0] r_gameState;
  logic [7:0]  r_lfsr;
  logic [3:0]  r_idx;
  logic [31:0] r_holdCnt;

  logic [3:0] w_key;
  logic       w_keyValid;
  logic [7:0] w_drawValue;
  logic [7:0] w_entryByte;
  logic       w_endgame;

  keypad_scanner #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_scanner (
    .clk        (clk),
    .rstn       (rstn),
    .i_cols     (keyboard_cols),
    .o_rows     (keyboard_rows),
    .o_key      (w_key),
    .o_key_valid(w_keyValid)
  );

`ifdef BINGO_HACK_EN
  assign w_drawValue = load_hack ? hack_number : r_lfsr;
`else
  logic w_unused;
  assign w_unused    = ^{hack_number, load_hack};
  assign w_drawValue = r_lfsr;
`endif

  assign w_entryByte = {r_entry[7:4], w_key};
  assign w_endgame   = (&r_gameState[7:0]) | (&r_gameState[15:8]);

  // Matched cards are overwritten with 00, which no later guess can hit again.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state     <= ST_WAIT_START;
      for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
      r_entry     <= 8'h00;
      r_half      <= 1'b0;
      r_wrPtr     <= 5'd0;
      r_guess     <= 8'h00;
      r_gameState <= 16'h0000;
      r_lfsr      <= 8'h01;
      r_idx       <= 4'd0;
      r_holdCnt   <= 32'd0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      case (r_state)
        ST_WAIT_START: begin
          if (w_keyValid) begin
            if (w_key == KEY_A) begin
              r_entry <= 8'h00;
              r_half  <= 1'b0;
            end else if (w_key == KEY_B) begin
              if (r_wrPtr == 5'd16) r_state <= ST_IDLE;
            end else if (w_key <= 4'd9 && r_wrPtr != 5'd16) begin
              if (!r_half) begin
                r_entry <= {w_key, 4'h0};
                r_half  <= 1'b1;
              end else begin
                r_half <= 1'b0;
                if (w_entryByte != 8'h00) begin
                  r_mem[r_wrPtr[3:0]] <= w_entryByte;
                  r_wrPtr             <= r_wrPtr + 5'd1;
                  r_entry             <= w_entryByte;
                end else begin
                  r_entry <= 8'h00;
                end
              end
            end
          end
        end
        ST_IDLE: begin
          if (next) begin
            r_guess <= w_drawValue;
            r_idx   <= 4'd0;
            r_state <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (r_mem[r_idx] == r_guess && r_guess != 8'h00) begin
            r_gameState[r_idx] <= 1'b1;
            r_mem[r_idx]       <= 8'h00;
          end
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            r_state   <= ST_HOLD;
            r_holdCnt <= 32'd0;
          end
        end
        ST_HOLD: begin
          if (r_holdCnt == HOLD_LAST) begin
            r_state <= w_endgame ? ST_END : ST_IDLE;
          end else begin
            r_holdCnt <= r_holdCnt + 32'd1;
          end
        end
        ST_END: begin
          r_state <= ST_END;
        end
        default: r_state <= ST_WAIT_START;
      endcase
    end
  end

  assign hex_selcted_number_1 = seg7(r_entry[7:4]);
  assign hex_selcted_number_2 = seg7(r_entry[3:0]);
  assign hex_gessed_number_1  = seg7(r_guess[7:4]);
  assign hex_gessed_number_2  = seg7(r_guess[3:0]);
  assign game_state_leds      = r_gameState;

endmodule

// File: tb/tb_bingo_top.sv
// Self-checking bench for bingo_top: keypad model, transaction-level game
// model with its own LFSR, and a per-cycle compare of the score and guess outputs.
module tb_bingo_top;

  localparam int DB   = 20;
  localparam int HOLD = 50;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  keyboard_cols;
  logic [7:0]  hack_number;
  logic        load_hack;
  logic        next;
  logic [3:0]  keyboard_rows;
  logic [6:0]  hex_selcted_number_1;
  logic [6:0]  hex_selcted_number_2;
  logic [6:0]  hex_gessed_number_1;
  logic [6:0]  hex_gessed_number_2;
  logic [15:0] game_state_leds;

  always #5 clk = ~clk;

  bingo_top #(.DEBOUNCE_COUNT(DB), .HOLD_COUNT(HOLD)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .keyboard_cols       (keyboard_cols),
    .hack_number         (hack_number),
    .load_hack           (load_hack),
    .next                (next),
    .keyboard_rows       (keyboard_rows),
    .hex_selcted_number_1(hex_selcted_number_1),
    .hex_selcted_number_2(hex_selcted_number_2),
    .hex_gessed_number_1 (hex_gessed_number_1),
    .hex_gessed_number_2 (hex_gessed_number_2),
    .game_state_leds     (game_state_leds)
  );

  int total = 0;
  int bad   = 0;

  // A held key only closes its column while the scanner drives its row.
  logic       keyDown;
  logic [3:0] keyRow;
  logic [2:0] keyCol;
  assign keyboard_cols = (keyDown && keyboard_rows == keyRow) ? keyCol : 3'b000;

  logic [6:0]  segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0]  mLfsr;
  logic [7:0]  mMem [16];
  logic [15:0] mLeds;
  logic [7:0]  mGuess;
  logic [7:0]  mEntry;
  logic        mHalf;
  int          mPtr;
  int          mState;
  logic        chkEn;

  function automatic logic [7:0] lfsrNext(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  always @(posedge clk) mLfsr <= rstn ? 8'h01 : lfsrNext(mLfsr);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("leds", 32'(game_state_leds), 32'(mLeds));
      checkOutput("guessTens", 32'(hex_gessed_number_1), 32'(segTab[mGuess[7:4]]));
      checkOutput("guessUnits", 32'(hex_gessed_number_2), 32'(segTab[mGuess[3:0]]));
      checkOutput("rowsOnehot", 32'($onehot(keyboard_rows)), 32'd1);
    end
  end

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mMem[i] = 8'h00;
    mLeds = 16'h0; mGuess = 8'h00; mEntry = 8'h00; mHalf = 1'b0; mPtr = 0; mState = 0;
  endtask

  task automatic modelKey(input logic [3:0] k);
    logic [7:0] v;
    if (mState != 0) return;
    if (k == 4'hA) begin
      mEntry = 8'h00; mHalf = 1'b0;
    end else if (k == 4'hB) begin
      if (mPtr == 16) mState = 1;
    end else if (mPtr < 16) begin
      if (!mHalf) begin
        mEntry = {k, 4'h0}; mHalf = 1'b1;
      end else begin
        mHalf = 1'b0;
        v = {mEntry[7:4], k};
        if (v != 8'h00) begin
          mMem[mPtr] = v; mPtr++; mEntry = v;
        end else begin
          mEntry = 8'h00;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k, input int hold, input int rel);
    case (k)
      4'd1, 4'd2, 4'd3: keyRow = 4'b1000;
      4'd4, 4'd5, 4'd6: keyRow = 4'b0100;
      4'd7, 4'd8, 4'd9: keyRow = 4'b0010;
      default:          keyRow = 4'b0001;
    endcase
    case (k)
      4'd1, 4'd4, 4'd7, 4'hA: keyCol = 3'b100;
      4'd2, 4'd5, 4'd8, 4'd0: keyCol = 3'b010;
      default:                keyCol = 3'b001;
    endcase
    keyDown = 1'b1;
    repeat (hold) @(negedge clk);
    keyDown = 1'b0;
    repeat (rel) @(negedge clk);
    modelKey(k);
    checkOutput("entryTens", 32'(hex_selcted_number_1), 32'(segTab[mEntry[7:4]]));
    checkOutput("entryUnits", 32'(hex_selcted_number_2), 32'(segTab[mEntry[3:0]]));
  endtask

  task automatic enterNumber(input logic [7:0] v, input int hold, input int rel);
    applyStimulus(v[7:4], hold, rel);
    applyStimulus(v[3:0], hold, rel);
  endtask

  task automatic checkMem();
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("mem%0d", i), 32'(dut.r_mem[i]), 32'(mMem[i]));
  endtask

  task automatic doDraw(input bit targeted, input logic [7:0] target, input bit dropTest);
    logic [7:0] g;
    int guard;
    chkEn = 1'b0;
    @(negedge clk);
`ifdef BINGO_HACK_EN
    load_hack   = targeted;
    hack_number = targeted ? target : 8'($urandom);
    if (!targeted) repeat ($urandom_range(0, 7)) @(negedge clk);
    g = targeted ? target : mLfsr;
`else
    load_hack   = 1'($urandom_range(0, 1));
    hack_number = 8'($urandom);
    if (targeted && mState == 1) begin
      guard = 0;
      while (mLfsr != target && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("lfsrReach", 32'(mLfsr), 32'(target));
    end else begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
    end
    g = mLfsr;
`endif
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    if (dropTest) begin
      repeat (29) @(negedge clk);
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      repeat (40) @(negedge clk);
    end else begin
      repeat (16 + HOLD + 4) @(negedge clk);
    end
    if (mState == 1) begin
      mGuess = g;
      for (int i = 0; i < 16; i++) begin
        if (g != 8'h00 && mMem[i] == g) begin
          mMem[i] = 8'h00;
          mLeds[i] = 1'b1;
        end
      end
      if (mLeds[7:0] == 8'hFF || mLeds[15:8] == 8'hFF) mState = 4;
    end
    checkOutput("stateAfterDraw", 32'(dut.r_state), 32'(mState));
    checkMem();
    chkEn = 1'b1;
  endtask

  initial begin
    logic [7:0] card;
    logic [7:0] dup;
    rstn = 1'b1; keyDown = 1'b0; keyRow = 4'b1000; keyCol = 3'b000;
    hack_number = 8'h00; load_hack = 1'b0; next = 1'b0; chkEn = 1'b0;
    modelReset();
    repeat (4) @(negedge clk);
    checkOutput("resetRows", 32'(keyboard_rows), 32'h8);
    checkOutput("resetSel1", 32'(hex_selcted_number_1), 32'h3F);
    checkOutput("resetSel2", 32'(hex_selcted_number_2), 32'h3F);
    checkOutput("resetGs1", 32'(hex_gessed_number_1), 32'h3F);
    checkOutput("resetGs2", 32'(hex_gessed_number_2), 32'h3F);
    checkOutput("resetLeds", 32'(game_state_leds), 32'h0);
    checkOutput("resetState", 32'(dut.r_state), 32'd0);
    rstn = 1'b0;
    chkEn = 1'b1;

    $display("[TB] entering cards");
    applyStimulus(4'd9, 300, 300);
    checkOutput("halfEntryTens", 32'(hex_selcted_number_1), 32'h6F);
    applyStimulus(4'hA, 300, 300);
    applyStimulus(4'd0, 300, 300);
    applyStimulus(4'd0, 300, 300);
    for (int i = 1; i <= 5; i++) enterNumber(8'(i), 300, 300);
    applyStimulus(4'hB, 300, 300);
    checkOutput("bEarly", 32'(dut.r_state), 32'd0);
    for (int i = 6; i <= 8; i++) enterNumber(8'(i), 300, 300);
    for (int i = 8'h11; i <= 8'h18; i++) enterNumber(8'(i), 300, 300);
    applyStimulus(4'd3, 300, 300);
    checkMem();
    checkOutput("mem0Lit", 32'(dut.r_mem[0]), 32'h01);
    checkOutput("mem8Lit", 32'(dut.r_mem[8]), 32'h11);
    checkOutput("mem15Lit", 32'(dut.r_mem[15]), 32'h18);
    applyStimulus(4'hB, 300, 300);
    checkOutput("bFull", 32'(dut.r_state), 32'd1);

    $display("[TB] draws");
    doDraw(1'b1, 8'h05, 1'b1);
    checkOutput("hit05Leds", 32'(game_state_leds), 32'h0010);
    checkOutput("hit05Tens", 32'(hex_gessed_number_1), 32'h3F);
    checkOutput("hit05Units", 32'(hex_gessed_number_2), 32'h6D);
    checkOutput("hit05Mem", 32'(dut.r_mem[4]), 32'h00);
    doDraw(1'b1, 8'h05, 1'b0);
    checkOutput("repeat05Leds", 32'(game_state_leds), 32'h0010);
    for (int i = 0; i < 10; i++) doDraw(1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) doDraw(1'b1, 8'(i), 1'b0);
    checkOutput("p1Full", 32'(game_state_leds[7:0]), 32'hFF);
    checkOutput("endState", 32'(dut.r_state), 32'd4);
    for (int i = 0; i < 3; i++) doDraw(1'b1, 8'h11, 1'b0);
    checkOutput("endStays", 32'(dut.r_state), 32'd4);

    $display("[TB] second game");
    chkEn = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    modelReset();
    chkEn = 1'b1;
    dup = 8'h42;
    for (int i = 0; i < 16; i++) begin
      card = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if (card == 8'h00) card = 8'h01;
      if (i == 3 || i == 12) card = dup;
      enterNumber(card, 60, 60);
    end
    applyStimulus(4'hB, 60, 60);
    checkOutput("bFull2", 32'(dut.r_state), 32'd1);
    doDraw(1'b1, dup, 1'b0);
    checkOutput("dupBoth", 32'({game_state_leds[12], game_state_leds[3]}), 32'h3);

    chkEn = 1'b0;
    @(negedge clk);
    load_hack = 1'b0;
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("abortRows", 32'(keyboard_rows), 32'h8);
    checkOutput("abortLeds", 32'(game_state_leds), 32'h0);
    checkOutput("abortGs1", 32'(hex_gessed_number_1), 32'h3F);
    checkOutput("abortGs2", 32'(hex_gessed_number_2), 32'h3F);
    checkOutput("abortSel1", 32'(hex_selcted_number_1), 32'h3F);
    checkOutput("abortState", 32'(dut.r_state), 32'd0);
    checkOutput("abortMem12", 32'(dut.r_mem[12]), 32'h00);
    rstn = 1'b0;
    modelReset();
    chkEn = 1'b1;
    repeat (10) @(negedge clk);
    chkEn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
